// File: rtl/key_hit_decoder.sv
// Turns a pointer position and button press over the on-screen keyboard into
// note start/end pulses, with a debounced press and a hold length counted in ticks.
module key_hit_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TICK_CYCLES     = 1000,
    parameter int unsigned LEN_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             press,
    input  logic [9:0]       x,
    input  logic [8:0]       y,
    input  logic             octave,
    output logic [4:0]       note,
    output logic             note_valid,
    output logic             finish_len,
    output logic [LEN_W-1:0] len,
    output logic             active
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_hit;
    logic [3:0]       w_semi;
    logic [4:0]       w_note_nxt;
    logic             r_filt;
    logic             r_filt_d;
    logic [DB_W-1:0]  r_db_cnt;
    logic [TK_W-1:0]  r_tick;
    logic [3:0]       r_semi;
    logic [4:0]       r_note;
    logic [LEN_W-1:0] r_len;
    logic             r_note_valid;
    logic             r_finish_len;
    logic             r_active;
    logic             w_rise;
    logic             w_ok;
    logic             w_start;
    logic             w_finish;

    // Black keys take precedence in the upper band; white key index is (x-1)/54 via thresholds.
    always_comb begin
        w_hit  = 1'b0;
        w_semi = 4'd0;
        if (x >= 10'd1 && x <= 10'd378 && y <= 9'd229) begin
            w_hit = 1'b1;
            if (y < 9'd132 && x >= 10'd37 && x <= 10'd72)
                w_semi = 4'd1;
            else if (y < 9'd132 && x >= 10'd91 && x <= 10'd126)
                w_semi = 4'd3;
            else if (y < 9'd132 && x >= 10'd199 && x <= 10'd234)
                w_semi = 4'd6;
            else if (y < 9'd132 && x >= 10'd253 && x <= 10'd288)
                w_semi = 4'd8;
            else if (y < 9'd132 && x >= 10'd307 && x <= 10'd342)
                w_semi = 4'd10;
            else if (x <= 10'd54)
                w_semi = 4'd0;
            else if (x <= 10'd108)
                w_semi = 4'd2;
            else if (x <= 10'd162)
                w_semi = 4'd4;
            else if (x <= 10'd216)
                w_semi = 4'd5;
            else if (x <= 10'd270)
                w_semi = 4'd7;
            else if (x <= 10'd324)
                w_semi = 4'd9;
            else
                w_semi = 4'd11;
        end
    end

    assign w_note_nxt = (octave ? 5'd12 : 5'd0) + {1'b0, w_semi};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filt   <= 1'b0;
            r_filt_d <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_filt_d <= r_filt;
            if (press != r_filt) begin
                if (r_db_cnt == DB_LAST) begin
                    r_filt   <= press;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign w_rise = r_filt & ~r_filt_d;
    assign w_ok   = enable & r_filt & w_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_rise && w_ok) w_state_nxt = ST_HELD;
            ST_HELD: begin
                if (!enable || !r_filt || !w_hit)
                    w_state_nxt = ST_IDLE;
                else if (w_semi != r_semi)
                    w_state_nxt = ST_GAP;
            end
            ST_GAP:  w_state_nxt = w_ok ? ST_HELD : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_start  = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            ST_IDLE: w_start  = w_rise && w_ok;
            ST_HELD: w_finish = (w_state_nxt != ST_HELD);
            ST_GAP:  w_start  = w_ok;
            default: ;
        endcase
    end

    // The tick on the finishing cycle is still counted so finish_len shows the final length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick       <= '0;
            r_semi       <= '0;
            r_note       <= '0;
            r_len        <= '0;
            r_note_valid <= 1'b0;
            r_finish_len <= 1'b0;
            r_active     <= 1'b0;
        end else begin
            r_note_valid <= w_start;
            r_finish_len <= w_finish;
            if (w_start) begin
                r_semi   <= w_semi;
                r_note   <= w_note_nxt;
                r_len    <= '0;
                r_tick   <= '0;
                r_active <= 1'b1;
            end else if (r_state == ST_HELD) begin
                if (r_tick == TK_LAST) begin
                    r_tick <= '0;
                    if (r_len != '1)
                        r_len <= r_len + 1'b1;
                end else begin
                    r_tick <= r_tick + 1'b1;
                end
                if (w_finish)
                    r_active <= 1'b0;
            end
        end
    end

    assign note       = r_note;
    assign note_valid = r_note_valid;
    assign finish_len = r_finish_len;
    assign len        = r_len;
    assign active     = r_active;

endmodule

// File: tb/tb_key_hit_decoder.sv
// Directed bench for key_hit_decoder: expected note/finish events are queued by
// the stimulus and checked by a monitor; a second instance checks len saturation.
module tb_key_hit_decoder;

    localparam int D = 4;
    localparam int T = 10;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b1;
    logic       press  = 1'b0;
    logic       octave = 1'b0;
    logic [9:0] x      = '0;
    logic [8:0] y      = '0;

    logic [4:0] note,  note2;
    logic       note_valid, note_valid2;
    logic       finish_len, finish_len2;
    logic [7:0] len,   len2;
    logic       active, active2;

    key_hit_decoder #(.DEBOUNCE_CYCLES(D), .TICK_CYCLES(T), .LEN_W(8)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .press(press),
        .x(x), .y(y), .octave(octave),
        .note(note), .note_valid(note_valid), .finish_len(finish_len),
        .len(len), .active(active)
    );

    key_hit_decoder #(.DEBOUNCE_CYCLES(D), .TICK_CYCLES(1), .LEN_W(8)) u_dut_t1 (
        .clk(clk), .reset(reset), .enable(enable), .press(press),
        .x(x), .y(y), .octave(octave),
        .note(note2), .note_valid(note_valid2), .finish_len(finish_len2),
        .len(len2), .active(active2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit fin;
        int val;
        int at;
    } ev_t;

    ev_t exp_q[$];
    ev_t m_e;
    int  errors = 0;
    int  checks = 0;
    int  st     = 0;
    int  st2    = 0;
    int  exp2;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic exp_start(input int nt, input int at);
        exp_q.push_back('{fin: 1'b0, val: nt, at: at});
        st = at;
    endtask

    task automatic exp_finish(input int at);
        int l;
        l = (at - st) / T;
        if (l > 255) l = 255;
        exp_q.push_back('{fin: 1'b1, val: l, at: at});
    endtask

    task automatic press_on(input int px, input int py, input bit oc, input int nt);
        x      = 10'(px);
        y      = 9'(py);
        octave = oc;
        press  = 1'b1;
        exp_start(nt, cyc + D + 1);
    endtask

    task automatic release_off();
        press = 1'b0;
        exp_finish(cyc + D + 1);
        tick(D + 3);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_note"}, int'(note), 0);
        chk({tag, "_nv"},   int'(note_valid), 0);
        chk({tag, "_fl"},   int'(finish_len), 0);
        chk({tag, "_len"},  int'(len), 0);
        chk({tag, "_act"},  int'(active), 0);
        chk({tag, "_len2"}, int'(len2), 0);
        chk({tag, "_act2"}, int'(active2), 0);
    endtask

    always @(negedge clk) begin
        if (!reset && (note_valid || finish_len)) begin
            checks++;
            if (note_valid && finish_len) begin
                errors++;
                $display("FAIL overlap nv=1 fl=1 at cycle %0d required one pulse", cyc);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event nv=%0d fl=%0d note=%0d len=%0d at cycle %0d required none",
                         note_valid, finish_len, note, len, cyc);
            end else begin
                m_e = exp_q.pop_front();
                if (m_e.fin != finish_len || m_e.at != cyc ||
                    (finish_len ? (int'(len) != m_e.val) : (int'(note) != m_e.val)) ||
                    active != !m_e.fin) begin
                    errors++;
                    $display("FAIL event actual fl=%0d note=%0d len=%0d act=%0d cyc=%0d required fl=%0d val=%0d act=%0d cyc=%0d",
                             finish_len, note, len, active, cyc, m_e.fin, m_e.val, !m_e.fin, m_e.at);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (note_valid2) st2 = cyc;
            if (finish_len2) begin
                exp2 = cyc - st2;
                if (exp2 > 255) exp2 = 255;
                checks++;
                if (int'(len2) != exp2) begin
                    errors++;
                    $display("FAIL len_tick1 actual=%0d required=%0d", len2, exp2);
                end
            end
        end
    end

    int tx[11]  = '{37, 72, 36, 73, 55, 55, 378, 342, 343, 91, 126};
    int ty[11]  = '{100, 100, 100, 100, 131, 132, 229, 131, 100, 131, 50};
    bit toc[11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    int tn[11]  = '{1, 1, 0, 2, 1, 2, 23, 10, 11, 15, 3};

    initial begin
        tick(3);
        chk_zero("reset");
        reset = 1'b0;
        tick(2);

        press_on(28, 176, 0, 0);
        tick(55);
        release_off();

        press_on(55, 88, 1, 13);
        tick(20);
        release_off();

        press_on(50, 150, 0, 0);
        tick(12);
        release_off();

        for (int i = 0; i < 11; i++) begin
            press_on(tx[i], ty[i], toc[i], tn[i]);
            tick(15);
            release_off();
        end

        // Short glitch must not start a note; the stable press after it does.
        x = 10'd200; y = 9'd200; press = 1'b1;
        tick(2);
        press = 1'b0;
        tick(2);
        press_on(200, 200, 0, 5);
        tick(25);
        release_off();

        press_on(82, 176, 0, 2);
        tick(30);
        x = 10'd136;
        exp_finish(cyc + 1);
        exp_start(4, cyc + 2);
        tick(20);
        release_off();

        press_on(28, 176, 0, 0);
        tick(10);
        octave = 1'b1;
        tick(10);
        release_off();

        x = 10'd0; y = 9'd100; press = 1'b1;
        tick(D + 5);
        x = 10'd100;
        tick(5);
        press = 1'b0;
        tick(D + 3);
        x = 10'd100; y = 9'd240; press = 1'b1;
        tick(D + 5);
        press = 1'b0;
        tick(D + 3);

        press_on(100, 176, 0, 2);
        tick(20);
        x = 10'd380;
        exp_finish(cyc + 1);
        tick(10);
        press = 1'b0;
        tick(D + 3);

        press_on(300, 176, 0, 9);
        tick(20);
        enable = 1'b0;
        exp_finish(cyc + 1);
        tick(5);
        enable = 1'b1;
        tick(5);
        press = 1'b0;
        tick(D + 3);

        press_on(28, 176, 1, 12);
        tick(2600);
        release_off();

        press_on(28, 176, 0, 0);
        tick(20);
        reset = 1'b1;
        press = 1'b0;
        #1;
        chk_zero("midreset");
        tick(2);
        reset = 1'b0;
        tick(D + 3);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
        chk("pending_events", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
